// File: rtl/adc_multi_sampler.sv
// adc_multi_sampler: capture sequencer for NUM_CH I2C `adc` instances.
// Starts all channels together, waits until every channel has gone busy,
// then captures each result independently. Optionally averages
// 2^AVG_LOG2 rounds per published result, repeats batches in continuous
// mode, and aborts a round that exceeds TIMEOUT_CYCLES.
module adc_multi_sampler #(
    parameter int NUM_CH         = 2,
    parameter int AVG_LOG2       = 0,
    parameter int PERIOD_CYCLES  = 27000000,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trigger,
    input  logic                 continuous,
    input  logic [NUM_CH-1:0]    adc_ready,
    input  logic [16*NUM_CH-1:0] adc_data,
    output logic [NUM_CH-1:0]    adc_enable,
    output logic [16*NUM_CH-1:0] raw_out,
    output logic [12*NUM_CH-1:0] volt_out,
    output logic                 sample_valid,
    output logic                 timeout_pulse,
    output logic [NUM_CH-1:0]    ch_timeout,
    output logic                 busy,
    output logic [15:0]          batch_count
);

    localparam int AW = 12 + AVG_LOG2;
    localparam int RW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

    localparam logic [RW-1:0]     ROUND_LAST = RW'((1 << AVG_LOG2) - 1);
    localparam logic [TW-1:0]     TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0]     HOLD_LOAD  = PW'(PERIOD_CYCLES - 1);
    localparam logic [NUM_CH-1:0] ALL_CH     = {NUM_CH{1'b1}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_PUBLISH = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    // Negative readings clamp to zero; otherwise keep the 12 magnitude bits.
    function automatic logic [11:0] clamp12(input logic [15:0] d);
        return d[15] ? 12'd0 : d[14:3];
    endfunction

    // Truncating divide of the accumulated sum by the number of rounds.
    function automatic logic [11:0] avg_of(input logic [AW-1:0] a);
        return 12'(a >> AVG_LOG2);
    endfunction

    logic [2:0]        state;
    logic [NUM_CH-1:0] done;
    logic [AW-1:0]     acc [NUM_CH];
    logic [RW-1:0]     round;
    logic [TW-1:0]     tcnt;
    logic [PW-1:0]     hcnt;
    logic [NUM_CH-1:0] cap_mask;
    logic [NUM_CH-1:0] done_next;
    logic              abort;
    logic              start_batch;

    // Per-edge decisions: which channels capture, whether the round aborts
    // (a capture that completes the round beats the time limit), and
    // whether a new batch starts.
    always_comb begin
        cap_mask = '0;
        if (state == S_CAPTURE) begin
            cap_mask = adc_ready & ~done;
        end
        done_next   = done | cap_mask;
        abort       = ((state == S_ARM) || ((state == S_CAPTURE) && (done != ALL_CH))) &&
                      (tcnt >= TO_LAST) && (done_next != ALL_CH);
        start_batch = ((state == S_IDLE) && (trigger || continuous)) ||
                      ((state == S_HOLDOFF) && continuous && (hcnt == '0));
    end

    assign busy = (state != S_IDLE);

    // Sequencer state, capture registers, accumulators and published outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            done          <= '0;
            round         <= '0;
            tcnt          <= '0;
            hcnt          <= '0;
            adc_enable    <= '0;
            raw_out       <= '0;
            volt_out      <= '0;
            sample_valid  <= 1'b0;
            timeout_pulse <= 1'b0;
            ch_timeout    <= '0;
            batch_count   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
        end else begin
            sample_valid  <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    state <= S_IDLE;
                end
                S_ARM: begin
                    // Only move on once every channel has dropped ready, so a
                    // ready left over from the previous conversion is never taken.
                    tcnt <= tcnt + 1'b1;
                    if (adc_ready == '0) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (done == ALL_CH) begin
                        if (round != ROUND_LAST) begin
                            // Every enable was dropped at its capture edge, so
                            // re-raising here leaves at least one low cycle.
                            round      <= round + 1'b1;
                            done       <= '0;
                            adc_enable <= ALL_CH;
                            tcnt       <= '0;
                            state      <= S_ARM;
                        end else begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                volt_out[12*i +: 12] <= avg_of(acc[i]);
                            end
                            sample_valid <= 1'b1;
                            batch_count  <= batch_count + 16'd1;
                            state        <= S_PUBLISH;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (cap_mask[i]) begin
                                raw_out[16*i +: 16] <= adc_data[16*i +: 16];
                                acc[i]              <= acc[i] + AW'(clamp12(adc_data[16*i +: 16]));
                                adc_enable[i]       <= 1'b0;
                            end
                        end
                        done <= done_next;
                    end
                end
                S_PUBLISH: begin
                    hcnt  <= HOLD_LOAD;
                    state <= continuous ? S_HOLDOFF : S_IDLE;
                end
                S_HOLDOFF: begin
                    if (!continuous) begin
                        state <= S_IDLE;
                    end else if (hcnt != '0) begin
                        hcnt <= hcnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Abandon the round: keep raw words already taken, publish nothing.
            if (abort) begin
                adc_enable    <= '0;
                ch_timeout    <= ~done_next;
                timeout_pulse <= 1'b1;
                hcnt          <= HOLD_LOAD;
                state         <= continuous ? S_HOLDOFF : S_IDLE;
            end

            if (start_batch) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    acc[i] <= '0;
                end
                round      <= '0;
                done       <= '0;
                ch_timeout <= '0;
                tcnt       <= '0;
                adc_enable <= ALL_CH;
                state      <= S_ARM;
            end
        end
    end

endmodule

// File: tb/tb_adc_multi_sampler.sv
// Bench for adc_multi_sampler: two instances (no averaging with short
// timeout/period, and 4x averaging), each fed by a simple behavioural ADC
// model; published results are checked against a queue of expectations.
module tb_adc_multi_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic        a_trig, a_cont, b_trig, b_cont;
    logic [1:0]  a_rdy, b_rdy, a_en, b_en, a_cht, b_cht;
    logic [31:0] a_dat, b_dat, a_raw, b_raw;
    logic [23:0] a_volt, b_volt;
    logic        a_sv, b_sv, a_to, b_to, a_busy, b_busy;
    logic [15:0] a_bc, b_bc;

    adc_multi_sampler #(.NUM_CH(2), .AVG_LOG2(0), .PERIOD_CYCLES(20), .TIMEOUT_CYCLES(100)) dut_a (
        .clk(clk), .rst_n(rst_n), .trigger(a_trig), .continuous(a_cont),
        .adc_ready(a_rdy), .adc_data(a_dat), .adc_enable(a_en), .raw_out(a_raw),
        .volt_out(a_volt), .sample_valid(a_sv), .timeout_pulse(a_to),
        .ch_timeout(a_cht), .busy(a_busy), .batch_count(a_bc)
    );

    adc_multi_sampler #(.NUM_CH(2), .AVG_LOG2(2), .PERIOD_CYCLES(20), .TIMEOUT_CYCLES(1000)) dut_b (
        .clk(clk), .rst_n(rst_n), .trigger(b_trig), .continuous(b_cont),
        .adc_ready(b_rdy), .adc_data(b_dat), .adc_enable(b_en), .raw_out(b_raw),
        .volt_out(b_volt), .sample_valid(b_sv), .timeout_pulse(b_to),
        .ch_timeout(b_cht), .busy(b_busy), .batch_count(b_bc)
    );

    // ---------------- behavioural ADC model (index 0 = dut_a, 1 = dut_b)
    logic [1:0]  en_v [2];
    logic [1:0]  rdy_v [2];
    logic [31:0] dat_v [2];
    logic [1:0]  en_d [2];
    logic [15:0] samp [2][2][8];
    int          lat [2][2];
    int          drp [2][2];
    int          cnt [2][2];
    int          sidx [2][2];
    logic        mdl_clr;

    assign en_v[0] = a_en;
    assign en_v[1] = b_en;
    assign a_rdy   = rdy_v[0];
    assign b_rdy   = rdy_v[1];
    assign a_dat   = dat_v[0];
    assign b_dat   = dat_v[1];

    // Ready drops drp cycles after enable rises, returns with the next sample at lat (0 = never).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                en_d[u]  <= 2'b00;
                rdy_v[u] <= 2'b11;
                dat_v[u] <= 32'h0;
                for (int c = 0; c < 2; c++) begin
                    cnt[u][c]  <= 0;
                    sidx[u][c] <= 0;
                end
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                en_d[u] <= en_v[u];
                for (int c = 0; c < 2; c++) begin
                    if (mdl_clr) sidx[u][c] <= 0;
                    if (en_v[u][c] && !en_d[u][c]) begin
                        cnt[u][c] <= 1;
                    end else if (cnt[u][c] > 0) begin
                        cnt[u][c] <= cnt[u][c] + 1;
                        if (cnt[u][c] == drp[u][c]) rdy_v[u][c] <= 1'b0;
                        if (lat[u][c] != 0 && cnt[u][c] == lat[u][c]) begin
                            rdy_v[u][c]          <= 1'b1;
                            dat_v[u][16*c +: 16] <= samp[u][c][sidx[u][c] & 7];
                            sidx[u][c]           <= sidx[u][c] + 1;
                            cnt[u][c]            <= 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- checking
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic        to;
        logic [31:0] raw;
        logic [23:0] volt;
        logic [15:0] bc;
        logic [1:0]  cht;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   a_nsv = 0;
    int   b_nsv = 0;
    int   b_rise0 = 0;
    logic b_en0_d = 1'b0;

    function automatic exp_t mk(input logic to, input logic [15:0] r1, input logic [15:0] r0,
                                input logic [11:0] v1, input logic [11:0] v0,
                                input logic [15:0] bc, input logic [1:0] cht);
        exp_t e;
        e.to   = to;
        e.raw  = {r1, r0};
        e.volt = {v1, v0};
        e.bc   = bc;
        e.cht  = cht;
        return e;
    endfunction

    // Scoreboard for dut_a: every publish or abort pops one expectation.
    always @(negedge clk) begin
        if (a_sv === 1'b1 || a_to === 1'b1) begin
            check("a_out_expected", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                check("a_kind", 64'(a_to), 64'(ea.to));
                check("a_raw", 64'(a_raw), 64'(ea.raw));
                check("a_volt", 64'(a_volt), 64'(ea.volt));
                check("a_batch_count", 64'(a_bc), 64'(ea.bc));
                check("a_ch_timeout", 64'(a_cht), 64'(ea.cht));
                if (ea.to) check("a_abort_enables", 64'(a_en), 64'd0);
            end
            if (a_sv === 1'b1) a_nsv <= a_nsv + 1;
        end
    end

    // Scoreboard for dut_b, plus count of channel-0 enable rises (one per round).
    always @(negedge clk) begin
        b_en0_d <= b_en[0];
        if (b_en[0] && !b_en0_d) b_rise0 <= b_rise0 + 1;
        if (b_sv === 1'b1 || b_to === 1'b1) begin
            check("b_out_expected", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                check("b_kind", 64'(b_to), 64'(eb.to));
                check("b_raw", 64'(b_raw), 64'(eb.raw));
                check("b_volt", 64'(b_volt), 64'(eb.volt));
                check("b_batch_count", 64'(b_bc), 64'(eb.bc));
            end
            if (b_sv === 1'b1) b_nsv <= b_nsv + 1;
        end
    end

    task automatic wait_a_sv(input int lim, input string tag);
        logic f;
        f = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (a_sv) begin f = 1'b1; break; end
        end
        check(tag, 64'(f), 64'd1);
    endtask

    task automatic wait_b_sv(input int lim, input string tag);
        logic f;
        f = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (b_sv) begin f = 1'b1; break; end
        end
        check(tag, 64'(f), 64'd1);
    endtask

    task automatic pulse_a_trig();
        a_trig = 1'b1;
        @(negedge clk);
        a_trig = 1'b0;
    endtask

    // ---------------- directed sequence
    initial begin
        logic f;
        int   n;
        int   nsv0;
        a_trig = 0; a_cont = 0; b_trig = 0; b_cont = 0; mdl_clr = 0;
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 2; c++) begin
                lat[u][c] = 10;
                drp[u][c] = 3;
                for (int k = 0; k < 8; k++) samp[u][c][k] = 16'h0;
            end

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_a_en", 64'(a_en), 64'd0);
        check("rst_a_raw", 64'(a_raw), 64'd0);
        check("rst_a_volt", 64'(a_volt), 64'd0);
        check("rst_a_pulses", 64'({a_sv, a_to}), 64'd0);
        check("rst_a_cht", 64'(a_cht), 64'd0);
        check("rst_a_busy", 64'(a_busy), 64'd0);
        check("rst_a_bc", 64'(a_bc), 64'd0);
        check("rst_b_state", 64'({b_en, b_busy, b_bc}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic two-channel batch, independent captures, trigger while busy ignored
        samp[0][0][0] = 16'h7FF8; lat[0][0] = 50;
        samp[0][1][0] = 16'h1230; lat[0][1] = 80;
        qa.push_back(mk(1'b0, 16'h1230, 16'h7FF8, 12'h246, 12'hFFF, 16'd1, 2'b00));
        pulse_a_trig();
        check("t1_en_start", 64'(a_en), 64'h3);
        check("t1_busy", 64'(a_busy), 64'd1);
        f = 1'b0;
        for (int k = 0; k < 20; k++) begin @(negedge clk); if (a_rdy == 2'b00) begin f = 1'b1; break; end end
        check("t1_ready_drop", 64'(f), 64'd1);
        f = 1'b0;
        for (int k = 0; k < 200; k++) begin @(negedge clk); if (a_rdy[0]) begin f = 1'b1; break; end end
        check("t1_ch0_ready", 64'(f), 64'd1);
        pulse_a_trig();
        check("t1_en_after_ch0", 64'(a_en), 64'h2);
        f = 1'b0;
        for (int k = 0; k < 200; k++) begin @(negedge clk); if (a_rdy[1]) begin f = 1'b1; break; end end
        check("t1_ch1_ready", 64'(f), 64'd1);
        @(negedge clk);
        check("t1_en_after_ch1", 64'(a_en), 64'd0);
        wait_a_sv(10, "t1_publish");
        repeat (6) @(negedge clk);
        check("t1_one_publish", 64'(a_nsv), 64'd1);
        check("t1_idle", 64'(a_busy), 64'd0);

        // Negative reading clamps to zero magnitude
        samp[0][0][1] = 16'h0100; lat[0][0] = 10;
        samp[0][1][1] = 16'h8010; lat[0][1] = 20;
        qa.push_back(mk(1'b0, 16'h8010, 16'h0100, 12'h000, 12'h020, 16'd2, 2'b00));
        pulse_a_trig();
        wait_a_sv(200, "t2_publish");
        repeat (3) @(negedge clk);

        // Four-round averaging on dut_b
        samp[1][0][0] = 16'h0008; samp[1][0][1] = 16'h0010;
        samp[1][0][2] = 16'h0018; samp[1][0][3] = 16'h0020;
        samp[1][1][0] = 16'h0100; samp[1][1][1] = 16'h0100;
        samp[1][1][2] = 16'h0200; samp[1][1][3] = 16'h0200;
        lat[1][0] = 6; lat[1][1] = 9;
        qb.push_back(mk(1'b0, 16'h0200, 16'h0020, 12'h030, 12'h002, 16'd1, 2'b00));
        b_trig = 1'b1;
        @(negedge clk);
        b_trig = 1'b0;
        wait_b_sv(400, "t3_publish");
        repeat (3) @(negedge clk);
        check("t3_rounds", 64'(b_rise0), 64'd4);
        check("t3_one_publish", 64'(b_nsv), 64'd1);

        // Timeout: channel 1 never returns
        samp[0][0][2] = 16'h0400; lat[0][0] = 10;
        lat[0][1] = 0;
        qa.push_back(mk(1'b1, 16'h8010, 16'h0400, 12'h000, 12'h020, 16'd2, 2'b10));
        pulse_a_trig();
        n = 0;
        f = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (a_to) begin f = 1'b1; break; end
            if (a_busy) n++;
            @(negedge clk);
        end
        check("t4_timeout_seen", 64'(f), 64'd1);
        check("t4_round_cycles", 64'(n), 64'd100);
        check("t4_busy_low", 64'(a_busy), 64'd0);
        @(negedge clk);
        check("t4_pulse_single", 64'(a_to), 64'd0);
        check("t4_cht_sticky", 64'(a_cht), 64'h2);

        // Asynchronous reset mid-capture
        samp[0][0][0] = 16'h0040; lat[0][0] = 5;
        samp[0][1][0] = 16'h0080; lat[0][1] = 40;
        pulse_a_trig();
        f = 1'b0;
        for (int k = 0; k < 100; k++) begin @(negedge clk); if (a_en == 2'b10) begin f = 1'b1; break; end end
        check("t5_mid_capture", 64'(f), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_en_async", 64'(a_en), 64'd0);
        check("t5_raw", 64'(a_raw), 64'd0);
        check("t5_volt", 64'(a_volt), 64'd0);
        check("t5_misc", 64'({a_sv, a_to, a_cht, a_busy}), 64'd0);
        check("t5_bc", 64'({a_bc, b_bc}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        qa.push_back(mk(1'b0, 16'h0080, 16'h0040, 12'h010, 12'h008, 16'd1, 2'b00));
        pulse_a_trig();
        wait_a_sv(200, "t5_clean_batch");
        repeat (3) @(negedge clk);

        // Continuous mode with an instant ADC
        for (int c = 0; c < 2; c++) begin lat[0][c] = 2; drp[0][c] = 1; end
        for (int k = 0; k < 8; k++) begin
            samp[0][0][k] = 16'(8 * (k + 1));
            samp[0][1][k] = 16'(256 * (k + 1));
        end
        mdl_clr = 1'b1;
        @(negedge clk);
        mdl_clr = 1'b0;
        for (int k = 0; k < 4; k++)
            qa.push_back(mk(1'b0, 16'(256 * (k + 1)), 16'(8 * (k + 1)),
                            12'(32 * (k + 1)), 12'(k + 1), 16'(2 + k), 2'b00));
        nsv0 = a_nsv;
        a_cont = 1'b1;
        wait_a_sv(100, "t6_publish1");
        n = 0;
        f = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (a_en != 2'b00) begin f = 1'b1; break; end
            n++;
        end
        check("t6_restart_seen", 64'(f), 64'd1);
        check("t6_holdoff_gap", 64'(n), 64'd20);
        wait_a_sv(100, "t6_publish2");
        wait_a_sv(100, "t6_publish3");
        f = 1'b0;
        for (int k = 0; k < 100; k++) begin @(negedge clk); if (a_en != 2'b00) begin f = 1'b1; break; end end
        check("t6_batch4_start", 64'(f), 64'd1);
        a_cont = 1'b0;
        wait_a_sv(100, "t6_publish4");
        repeat (40) @(negedge clk);
        check("t6_ends_idle", 64'({a_busy, a_en}), 64'd0);
        check("t6_publish_count", 64'(a_nsv - nsv0), 64'd4);

        // Dropping continuous during holdoff returns to idle on the next edge
        qa.push_back(mk(1'b0, 16'h0500, 16'h0028, 12'h0A0, 12'h005, 16'd6, 2'b00));
        a_cont = 1'b1;
        wait_a_sv(100, "t7_publish");
        @(negedge clk);
        check("t7_in_holdoff", 64'(a_busy), 64'd1);
        a_cont = 1'b0;
        @(negedge clk);
        check("t7_idle", 64'({a_busy, a_en}), 64'd0);
        repeat (30) @(negedge clk);
        check("t7_no_restart", 64'(a_busy), 64'd0);

        check("queue_a_drained", 64'(qa.size()), 64'd0);
        check("queue_b_drained", 64'(qb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
